// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit position counter width; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the one shared datapath resource of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell walked LSB-first over the operands.
//   state  | meaning
//   S_IDLE | waiting for start; results held
//   S_RUN  | one bit per clock through the shared cell
//   S_DONE | one-cycle done pulse; results valid
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] sum_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a   (ar[0]),
    .b   (br[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_co)
  );

  // New sum bit enters at the MSB so bit i lands at sum[i] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = fa_s;
    end else begin : g_wn
      assign sum_shift = {fa_s, sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ar    <= '0;
      br    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ar    <= a;
            br    <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum   <= sum_shift;
          ar    <= ar >> 1;
          br    <= br >> 1;
          carry <= fa_co;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB at this point
            ovf   <= carry ^ fa_co;
            cout  <= fa_co;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         done_cyc;
    string      name;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a DUT raises done.
  always @(negedge clock) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done8: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = q8.pop_front();
        chk({e.name, "_sum"},  32'(sum8),  32'(e.sum));
        chk({e.name, "_cout"}, 32'(cout8), 32'(e.cout));
        chk({e.name, "_ovf"},  32'(ovf8),  32'(e.ovf));
        chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done1: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = q1.pop_front();
        chk({e.name, "_sum"},  32'(sum1),  32'(e.sum));
        chk({e.name, "_cout"}, 32'(cout1), 32'(e.cout));
        chk({e.name, "_ovf"},  32'(ovf1),  32'(e.ovf));
        chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Issue one 8-bit add; returns at the negedge after the accepting edge.
  task automatic issue8(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic c, input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    int e0;
    @(negedge clock);
    a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
    e0 = cyc + 1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.done_cyc = e0 + 8; e.name = name;
    q8.push_back(e);
    @(negedge clock);
    start8 = 1'b0;
  endtask

  task automatic issue1(input string name, input logic av, input logic bv, input logic c,
                        input logic es, input logic ec, input logic eo);
    exp_t e;
    int e0;
    @(negedge clock);
    a1 = av; b1 = bv; cin1 = c; start1 = 1'b1;
    e0 = cyc + 1;
    e.sum = {7'd0, es}; e.cout = ec; e.ovf = eo; e.done_cyc = e0 + 1; e.name = name;
    q1.push_back(e);
    @(negedge clock);
    start1 = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    while ((q8.size() != 0 || q1.size() != 0) && k < max_cycles) begin
      @(negedge clock);
      k++;
    end
    if (q8.size() != 0 || q1.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", q8.size() + q1.size());
      q8.delete();
      q1.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int e0;
    exp_t e;

    repeat (3) @(negedge clock);
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_sum8",  32'(sum8),  0);
    chk("rst_cout8", 32'(cout8), 0);
    chk("rst_ovf8",  32'(ovf8),  0);
    chk("rst_sum1",  32'(sum1),  0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 0x5A + 0x33 also checks that busy lasts exactly WIDTH cycles
    issue8("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy8) busy_cnt++;
      @(negedge clock);
    end
    chk("busy_cycles", 32'(busy_cnt), 8);
    drain(40);

    issue8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drain(40);

    // start held for 20 edges; operands scrambled except on the accepting edges
    @(negedge clock);
    e0 = cyc + 1;
    start8 = 1'b1;
    cin8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 10) begin
        a8 = 8'h01; b8 = 8'h01;
        e.sum = 8'h02; e.cout = 1'b0; e.ovf = 1'b0; e.done_cyc = e0 + i + 8;
        e.name = (i == 0) ? "held_first" : "held_second";
        q8.push_back(e);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clock);
      cin8 = 1'b0;
    end
    start8 = 1'b0;
    drain(40);

    issue8("add_7f_00_c1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    drain(40);

    // reset sampled at E4 of a run: no done, outputs cleared
    @(negedge clock);
    a8 = 8'hAA; b8 = 8'h77; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrun_rst_busy", 32'(busy8), 0);
    chk("midrun_rst_done", 32'(done8), 0);
    chk("midrun_rst_sum",  32'(sum8),  0);
    chk("midrun_rst_cout", 32'(cout8), 0);
    chk("midrun_rst_ovf",  32'(ovf8),  0);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    issue8("after_rst_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    drain(40);

    issue1("w1_111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(10);
    issue1("w1_001", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that performs a WIDTH-bit addition with one shared `full_adder` cell and a carry flip-flop, processing one bit per clock. It accepts operands on a start strobe, sequences the cell through every bit position LSB-first, and then presents sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal alternative to the parallel ripple-carry adder on the lab board, driven from switches or an upstream FSM.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1 to 32.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A, captured on an accepted start.
- `b`  in  WIDTH  operand B, captured on an accepted start.
- `cin`  in  1  carry-in, captured on an accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  result register; holds until the next accepted start.
- `cout`  out  1  carry out of the MSB.
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; the state register is 2 bits.
- **IDLE:** on `start=1`:
  - load shift registers `ar<=a`, `br<=b`;
  - load `carry<=cin`, `cnt<=0`;
  - clear `sum` to 0;
  - go to RUN.
- **RUN:** each edge:
  - `full_adder` computes `s` and `co` from `ar[0]`, `br[0]` and `carry`;
  - `s` shifts into `sum` at the MSB, so after WIDTH shifts bit i sits at `sum[i]`;
  - `ar` and `br` shift right;
  - `carry<=co`;
  - when `cnt==WIDTH-1`, latch `ovf <= carry XOR co` and `cout<=co`, then go to DONE;
  - otherwise `cnt<=cnt+1`.
- **DONE:** `done=1` for exactly this one cycle; next edge goes unconditionally to IDLE.
- `start` in RUN or DONE is ignored. It is not queued.
- `start` held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- `sum`, `cout` and `ovf` hold their values through IDLE until the next accepted start.
- `sum` clears on start. `cout` and `ovf` keep their previous values during RUN and update only at the final bit.
- `busy` and `done` are decoded from the state register, not registered separately.
- `cnt` width is `$clog2(WIDTH)`, minimum 1 bit.
- WIDTH=1: RUN lasts one cycle, and `ovf` equals `cin XOR cout`.
- Sum arithmetic is modulo 2^WIDTH. The true result is {`cout`, `sum`}.
- **Reset:** takes priority over every state, including mid-RUN. It forces:
  - state IDLE;
  - `sum=0`, `cout=0`, `ovf=0`;
  - `busy=0`, `done=0`;
  - `cnt=0`, `carry=0`.

## Timing
- Start accepted at edge E0; `busy` is high from after E0 through edge E_WIDTH.
- RUN occupies WIDTH cycles, edges E1 to E_WIDTH.
- After E_WIDTH: `done=1`, `busy=0`, and `sum`, `cout` and `ovf` are valid.
- After E_WIDTH+1: back in IDLE, `done=0`.
- Latency from start edge to `done` high is WIDTH+1 edges. Throughput is one addition per WIDTH+2 cycles.
- No combinational path from any input to any output.

## Structure
- Sub-module: `full_adder` (a, b, cin -> s, cout), instantiated once. This is the shared datapath resource.
- Shared package `serial_add_pkg`:
  - state typedef/localparams `S_IDLE`, `S_RUN`, `S_DONE`;
  - count-width function.
- Controller FSM and datapath shift registers live in `serial_add_ctrl`. No further hierarchy.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, start 1 cycle -> `done` at E9; sum=0x8D, cout=0, ovf=1; `busy` high exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- `start` held high for 20 cycles with a=0x01, b=0x01 -> done pulses at E9 and E19, sum=0x02 each time; operands changed during RUN do not affect the result.
- Reset asserted at E4 of a run -> next cycle IDLE, all outputs 0, no `done`; a fresh start of a=0x10, b=0x20 yields 0x30.
- WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0, `done` at E2.
